// File: rtl/arb_txn_mux_if.sv
// Shared single-outstanding bus between arb_txn_mux (master) and the downstream target (slave).
interface arb_txn_mux_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output valid, addr, wdata, we,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wdata, we,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/arb_txn_mux.sv
// Transaction mux behind wrr_arbiter: accepts the granted requester, issues its
// transaction on the shared bus and returns the completion (or a timeout error)
// to that requester. The arbiter is masked while a transaction is in flight.
module arb_txn_mux #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        arb_req_o,
    input  logic [NUM_REQ-1:0]        arb_grant_i,
    arb_txn_mux_if.master             bus,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      busy_o
);

    localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    state_e              state_q;
    logic [OWN_W-1:0]    owner_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q;
    logic                bus_valid_q;
    logic                busy_q;

    logic                idle;
    logic [NUM_REQ-1:0]  g;
    logic                sel_hit;
    logic [OWN_W-1:0]    sel_k;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;

    // Requests reach the arbiter only while idle and out of reset; that path
    // never sees arb_grant_i, so the arbiter round trip cannot loop.
    assign idle      = rst_ni && (state_q == S_IDLE);
    assign arb_req_o = idle ? req_valid_i : '0;
    assign g         = arb_grant_i & req_valid_i & {NUM_REQ{idle}};

    // Lowest granted requester wins; extra grant bits (arbiter fault) are ignored.
    always_comb begin
        sel_hit   = 1'b0;
        sel_k     = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (g[i]) begin
                sel_hit   = 1'b1;
                sel_k     = OWN_W'(i);
                sel_addr  = req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata_i[i*DATA_W +: DATA_W];
                sel_we    = req_we_i[i];
            end
        end
    end

    assign req_ready_o = sel_hit ? (NUM_REQ'(1) << sel_k) : '0;

    // Transaction FSM: capture, issue with back-pressure, wait for completion or timeout.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            bus_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            case (state_q)
                S_IDLE: begin
                    if (sel_hit) begin
                        owner_q     <= sel_k;
                        addr_q      <= sel_addr;
                        wdata_q     <= sel_wdata;
                        we_q        <= sel_we;
                        bus_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.ready) begin
                        bus_valid_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus.rvalid) begin
                        rsp_valid_o <= NUM_REQ'(1) << owner_q;
                        rsp_rdata_o <= bus.rdata;
                        rsp_err_o   <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        rsp_valid_o <= NUM_REQ'(1) << owner_q;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    bus_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.valid = bus_valid_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
    assign bus.we    = we_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_arb_txn_mux.sv
// Bench for arb_txn_mux: reset/selection table, directed multi-cycle sequences,
// and a randomized run against a transaction-level timing model.
module tb_arb_txn_mux;

    localparam int unsigned NR = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_we;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     arb_req;
    logic [NR-1:0]     arb_grant;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              busy;

    logic [NR-1:0]     grant_drv;
    bit                use_rr;
    logic              rr_last;

    int n_vec = 0;
    int n_err = 0;

    arb_txn_mux_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    arb_txn_mux #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_we_i    (req_we),
        .req_ready_o (req_ready),
        .arb_req_o   (arb_req),
        .arb_grant_i (arb_grant),
        .bus         (bus),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Arbiter stand-in: fixed grant from the stimulus, or a 1:1 round robin.
    always_comb begin
        if (use_rr) begin
            if (arb_req == 2'b11) arb_grant = rr_last ? 2'b01 : 2'b10;
            else                  arb_grant = arb_req;
        end else begin
            arb_grant = grant_drv;
        end
    end

    // Round-robin pointer remembers the last requester granted.
    always @(posedge clk) begin
        if (!rst_n)                rr_last <= 1'b1;
        else if (arb_grant != '0)  rr_last <= arb_grant[1];
    end

    typedef struct packed {
        logic       rst;
        logic [1:0] valid;
        logic [1:0] grant;
        logic [1:0] exp_ready;
        logic [1:0] exp_arb;
    } vec_t;

    vec_t tbl [12];

    // random-phase model state
    bit          m_open;
    bit          m_idle;
    bit          m_issue;
    int          t_hs;
    int          t_rsp;
    int          rv_cyc;
    int          m_own;
    int          d;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic [DW-1:0] m_rv_data;
    logic [DW-1:0] m_exp_data;
    logic          m_exp_err;
    logic [1:0]    m_g;
    logic [1:0]    m_exp_ready;
    logic [1:0]    m_exp_rsp;
    logic [1:0]    exp2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_valid  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_we     = '0;
        grant_drv  = '0;
        bus.ready  = 1'b0;
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_bus_valid", 64'(bus.valid), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        chk("rst_rsp_err",   64'(rsp_err),   64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_bus_addr",  64'(bus.addr),  64'd0);
        chk("rst_bus_wdata", 64'(bus.wdata), 64'd0);
        chk("rst_bus_we",    64'(bus.we),    64'd0);
    endtask

    initial begin
        use_rr = 1'b0;
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs();

        // ---------------- combinational selection / reset gating table ----------------
        tbl[0]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00};
        tbl[1]  = '{1'b0, 2'b01, 2'b01, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[3]  = '{1'b1, 2'b01, 2'b00, 2'b00, 2'b01};
        tbl[4]  = '{1'b1, 2'b01, 2'b01, 2'b01, 2'b01};
        tbl[5]  = '{1'b1, 2'b10, 2'b10, 2'b10, 2'b10};
        tbl[6]  = '{1'b1, 2'b11, 2'b10, 2'b10, 2'b11};
        tbl[7]  = '{1'b1, 2'b11, 2'b01, 2'b01, 2'b11};
        tbl[8]  = '{1'b1, 2'b11, 2'b11, 2'b01, 2'b11};
        tbl[9]  = '{1'b1, 2'b01, 2'b10, 2'b00, 2'b01};
        tbl[10] = '{1'b1, 2'b10, 2'b11, 2'b10, 2'b10};
        tbl[11] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 12; i++) begin
            rst_n     = tbl[i].rst;
            req_valid = tbl[i].valid;
            grant_drv = tbl[i].grant;
            #1;
            chk("tbl_ready", 64'(req_ready), 64'(tbl[i].exp_ready));
            chk("tbl_arb",   64'(arb_req),   64'(tbl[i].exp_arb));
            req_valid = '0;
            grant_drv = '0;
            nxt();
            chk("tbl_busy", 64'(busy), 64'd0);
        end
        rst_n = 1'b1;

        // ---------------- single read ----------------
        req_valid = 2'b01; req_addr[31:0] = 32'h100; req_we = 2'b00; grant_drv = 2'b01;
        #1;
        chk("rd_ready", 64'(req_ready), 64'h1);
        nxt();
        req_valid = '0; grant_drv = '0; bus.ready = 1'b1;
        #1;
        chk("rd_bus_valid", 64'(bus.valid), 64'd1);
        chk("rd_bus_addr",  64'(bus.addr),  64'h100);
        chk("rd_bus_we",    64'(bus.we),    64'd0);
        nxt();
        bus.ready = 1'b0;
        #1;
        chk("rd_bus_valid_off", 64'(bus.valid), 64'd0);
        nxt();
        bus.rvalid = 1'b1; bus.rdata = 32'hDEADBEEF;
        #1;
        chk("rd_rsp_early", 64'(rsp_valid), 64'd0);
        nxt();
        bus.rvalid = 1'b0;
        #1;
        chk("rd_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("rd_rsp_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
        chk("rd_rsp_err",   64'(rsp_err),   64'd0);
        chk("rd_busy",      64'(busy),      64'd0);
        nxt();
        chk("rd_rsp_once",  64'(rsp_valid), 64'd0);
        chk("rd_rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);

        // ---------------- back-pressure on a write ----------------
        req_valid = 2'b10; req_addr[63:32] = 32'h20; req_wdata[63:32] = 32'h55;
        req_we = 2'b10; grant_drv = 2'b10;
        #1;
        chk("bp_ready", 64'(req_ready), 64'h2);
        nxt();
        req_valid = 2'b11; grant_drv = 2'b11; bus.ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", 64'(bus.valid), 64'd1);
            chk("bp_addr",  64'(bus.addr),  64'h20);
            chk("bp_wdata", 64'(bus.wdata), 64'h55);
            chk("bp_we",    64'(bus.we),    64'd1);
            chk("bp_arb",   64'(arb_req),   64'd0);
            chk("bp_ready0", 64'(req_ready), 64'd0);
            nxt();
        end
        req_valid = '0; grant_drv = '0; bus.ready = 1'b1;
        #1;
        chk("bp_valid_last", 64'(bus.valid), 64'd1);
        nxt();
        bus.ready = 1'b0; bus.rvalid = 1'b1; bus.rdata = '0;
        nxt();
        bus.rvalid = 1'b0;
        #1;
        chk("bp_rsp", 64'(rsp_valid), 64'h2);
        chk("bp_err", 64'(rsp_err),   64'd0);
        nxt();

        // ---------------- alternating requesters, zero-wait bus ----------------
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
        use_rr = 1'b1;
        req_valid = 2'b11; bus.ready = 1'b1; bus.rvalid = 1'b1;
        for (int c = 0; c < 18; c++) begin
            bus.rdata = 32'h1000 + 32'(c);
            #1;
            exp2 = (c % 3 == 0) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("alt_ready", 64'(req_ready), 64'(exp2));
            exp2 = (c % 3 == 0 && c >= 3) ? ((((c / 3) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("alt_rsp", 64'(rsp_valid), 64'(exp2));
            if (exp2 != 2'b00) chk("alt_rdata", 64'(rsp_rdata), 64'(32'h1000 + 32'(c - 1)));
            chk("alt_bus_valid", 64'(bus.valid), 64'((c % 3) == 1));
            nxt();
        end
        use_rr = 1'b0;
        clear_in();
        nxt();

        // ---------------- timeout, then a late completion ----------------
        req_valid = 2'b01; req_addr[31:0] = 32'h40; grant_drv = 2'b01;
        #1;
        chk("to_ready", 64'(req_ready), 64'h1);
        nxt();
        clear_in(); bus.ready = 1'b1;
        nxt();
        bus.ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("to_busy", 64'(busy), 64'd1);
            chk("to_no_rsp", 64'(rsp_valid), 64'd0);
            nxt();
        end
        #1;
        chk("to_rsp",   64'(rsp_valid), 64'h1);
        chk("to_err",   64'(rsp_err),   64'd1);
        chk("to_rdata", 64'(rsp_rdata), 64'd0);
        chk("to_idle",  64'(busy),      64'd0);
        nxt();
        bus.rvalid = 1'b1; bus.rdata = 32'h1234;
        nxt();
        bus.rvalid = 1'b0;
        #1;
        chk("late_no_rsp",   64'(rsp_valid), 64'd0);
        chk("late_err_hold", 64'(rsp_err),   64'd1);
        chk("late_rdata",    64'(rsp_rdata), 64'd0);
        nxt();

        // ---------------- completion on the last counter value ----------------
        req_valid = 2'b10; req_addr[63:32] = 32'h44; grant_drv = 2'b10;
        #1;
        chk("race_ready", 64'(req_ready), 64'h2);
        nxt();
        clear_in(); bus.ready = 1'b1;
        nxt();
        bus.ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) begin
                bus.rvalid = 1'b1; bus.rdata = 32'hCAFE;
            end
            #1;
            chk("race_no_rsp", 64'(rsp_valid), 64'd0);
            nxt();
        end
        bus.rvalid = 1'b0;
        #1;
        chk("race_rsp",   64'(rsp_valid), 64'h2);
        chk("race_err",   64'(rsp_err),   64'd0);
        chk("race_rdata", 64'(rsp_rdata), 64'hCAFE);
        nxt();

        // ---------------- reset while waiting ----------------
        req_valid = 2'b01; req_addr[31:0] = 32'h77; req_wdata[31:0] = 32'h99;
        req_we = 2'b01; grant_drv = 2'b01;
        nxt();
        clear_in(); bus.ready = 1'b1;
        nxt();
        bus.ready = 1'b0;
        nxt();
        rst_n = 1'b0; req_valid = 2'b11; grant_drv = 2'b11;
        #1;
        chk("rstw_arb",   64'(arb_req),   64'd0);
        chk("rstw_ready", 64'(req_ready), 64'd0);
        nxt();
        rst_n = 1'b1; clear_in();
        #1;
        chk_reset_outs();
        bus.rvalid = 1'b1; bus.rdata = 32'h3;
        nxt();
        bus.rvalid = 1'b0;
        #1;
        chk("rstw_no_rsp", 64'(rsp_valid), 64'd0);
        req_valid = 2'b10; req_addr[63:32] = 32'h88; grant_drv = 2'b10;
        #1;
        chk("rstw_ready2", 64'(req_ready), 64'h2);
        nxt();
        clear_in(); bus.ready = 1'b1;
        #1;
        chk("rstw_bus_valid", 64'(bus.valid), 64'd1);
        chk("rstw_bus_addr",  64'(bus.addr),  64'h88);
        nxt();
        bus.ready = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h5A;
        nxt();
        bus.rvalid = 1'b0;
        #1;
        chk("rstw_rsp",   64'(rsp_valid), 64'h2);
        chk("rstw_rdata", 64'(rsp_rdata), 64'h5A);
        nxt();

        // ---------------- randomized run vs. transaction timing model ----------------
        rst_n = 1'b0; clear_in();
        nxt();
        rst_n = 1'b1;
        m_open = 1'b0; t_hs = -1; t_rsp = -1; rv_cyc = -1; m_own = 0;
        m_exp_data = '0; m_exp_err = 1'b0; m_rv_data = '0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // the response cycle is already an idle cycle
            if (m_open && cyc == t_rsp) m_open = 1'b0;
            m_idle  = !m_open;
            m_issue = m_open && (t_hs < 0);

            req_valid = NR'($urandom);
            grant_drv = NR'($urandom);
            req_we    = NR'($urandom);
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            bus.ready = ($urandom_range(0, 2) == 0);
            bus.rdata = $urandom;
            if (cyc == rv_cyc) begin
                bus.rvalid = 1'b1;
                bus.rdata  = m_rv_data;
            end else if (!(m_open && t_hs >= 0)) begin
                bus.rvalid = ($urandom_range(0, 7) == 0);
            end else begin
                bus.rvalid = 1'b0;
            end
            #1;

            m_g = m_idle ? (grant_drv & req_valid) : 2'b00;
            m_exp_ready = m_g & 2'(~m_g + 2'd1);
            chk("rnd_arb",   64'(arb_req),   64'(m_idle ? req_valid : 2'b00));
            chk("rnd_ready", 64'(req_ready), 64'(m_exp_ready));
            chk("rnd_bus_valid", 64'(bus.valid), 64'(m_issue));
            if (m_issue) begin
                chk("rnd_bus_addr",  64'(bus.addr),  64'(m_addr));
                chk("rnd_bus_wdata", 64'(bus.wdata), 64'(m_wdata));
                chk("rnd_bus_we",    64'(bus.we),    64'(m_we));
            end
            m_exp_rsp = (cyc == t_rsp) ? ((m_own == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk("rnd_rsp", 64'(rsp_valid), 64'(m_exp_rsp));
            if (cyc == t_rsp) begin
                chk("rnd_rsp_rdata", 64'(rsp_rdata), 64'(m_exp_data));
                chk("rnd_rsp_err",   64'(rsp_err),   64'(m_exp_err));
            end
            chk("rnd_busy", 64'(busy), 64'(m_open));

            if (m_idle && m_g != 2'b00) begin
                m_open  = 1'b1;
                t_hs    = -1;
                m_own   = m_g[0] ? 0 : 1;
                m_addr  = req_addr[m_own*AW +: AW];
                m_wdata = req_wdata[m_own*DW +: DW];
                m_we    = req_we[m_own];
            end else if (m_issue && bus.ready) begin
                t_hs      = cyc;
                d         = int'($urandom_range(1, TO + 2));
                rv_cyc    = cyc + d;
                m_rv_data = $urandom;
                if (d <= int'(TO)) begin
                    t_rsp      = cyc + d + 1;
                    m_exp_data = m_rv_data;
                    m_exp_err  = 1'b0;
                end else begin
                    t_rsp      = cyc + 1 + int'(TO);
                    m_exp_data = '0;
                    m_exp_err  = 1'b1;
                end
            end
            nxt();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
